baw_card_eval: RTL and testbench

//  Evaluation datapath for the two-player Black-and-White card game (cards 0..8).
//  - Counts black/white cards left in each player's 9-bit hand mask.
//  - Encodes each player's one-hot card selection into a 4-bit card value.
//  - Compares the two played cards to produce the match result.

---
 rtl/baw_pkg.sv | 35 +++
 rtl/baw_onehot_enc.sv | 37 +++
 rtl/baw_card_eval.sv | 132 +++++++++++++
 tb/tb_baw_card_eval.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/baw_pkg.sv
// ----------------------------------------------------------------------------
// baw_pkg
//   Shared constants and helpers for the Black-and-White card game evaluation
//   datapath. Cards take values 0..NCARDS-1. Odd values are black and even
//   values are white.
//   Contents:
//     NCARDS               number of cards (fixed at 9)
//     MATCH_*              match_result encodings
//     BLACK_MASK           hand-mask bits that hold black cards (1,3,5,7)
//     WHITE_MASK           hand-mask bits that hold white cards (0,2,4,6,8)
//     popcount9()          set-bit count of a 9-bit hand mask
// ----------------------------------------------------------------------------
package baw_pkg;

    localparam int unsigned NCARDS = 9;

    localparam logic [1:0] MATCH_DRAW = 2'b00;
    localparam logic [1:0] MATCH_P1   = 2'b01;
    localparam logic [1:0] MATCH_P2   = 2'b10;
    localparam logic [1:0] MATCH_INV  = 2'b11;

    localparam logic [NCARDS-1:0] BLACK_MASK = 9'b010101010;
    localparam logic [NCARDS-1:0] WHITE_MASK = 9'b101010101;

    // At most 5 bits survive either colour mask, so 4 bits never overflow.
    function automatic logic [3:0] popcount9(input logic [NCARDS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int unsigned i = 0; i < NCARDS; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

endpackage : baw_pkg

// File: rtl/baw_onehot_enc.sv
// ----------------------------------------------------------------------------
// baw_onehot_enc
//   Converts a player's card selection into a card value.
//   The value is the index of the highest set bit. An all-zero selection
//   gives value 0. The flag reports whether exactly one bit was set.
//   Ports:
//     i_sel     in   9  card selection, bit i = card i
//     o_value   out  4  index of highest set bit (0 when i_sel == 0)
//     o_onehot  out  1  exactly one bit of i_sel is set
// ----------------------------------------------------------------------------
module baw_onehot_enc
    import baw_pkg::*;
(
    input  logic [NCARDS-1:0] i_sel,
    output logic [3:0]        o_value,
    output logic              o_onehot
);

    logic w_any;
    logic w_multi;

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        o_value = '0;
        for (int unsigned i = 0; i < NCARDS; i++) begin
            if (i_sel[i]) begin
                o_value = 4'(i);
            end
        end
    end

    // x & (x-1) clears the lowest set bit, so any remainder means >1 bit set.
    assign w_any    = |i_sel;
    assign w_multi  = |(i_sel & (i_sel - 9'd1));
    assign o_onehot = w_any & ~w_multi;

endmodule : baw_onehot_enc

// File: rtl/baw_card_eval.sv
// ----------------------------------------------------------------------------
// baw_card_eval
//   Evaluation datapath for the two-player Black-and-White card game.
//   - Registers the black/white card counts of each hand every cycle.
//   - On eval_en, captures both encoded selections and the match result.
//   Configuration macro:
//     BAW_ZERO_BEATS_EIGHT_EN  when defined, a valid 0 beats a valid 8.
//   Ports:
//     clk            in   1  rising-edge clock
//     reset          in   1  asynchronous active-high reset
//     p1_card        in   9  P1 remaining cards
//     p2_card        in   9  P2 remaining cards
//     p1_sel         in   9  P1 selection (expected one-hot)
//     p2_sel         in   9  P2 selection (expected one-hot)
//     eval_en        in   1  capture selections and compare
//     p1_black       out  4  black cards in p1_card
//     p1_white       out  4  white cards in p1_card
//     p2_black       out  4  black cards in p2_card
//     p2_white       out  4  white cards in p2_card
//     p1_hand        out  4  captured P1 card value
//     p2_hand        out  4  captured P2 card value
//     p1_hand_black  out  1  p1_hand[0]
//     p2_hand_black  out  1  p2_hand[0]
//     hand_valid     out  1  both captured selections were one-hot
//     match_result   out  2  00 draw, 01 P1, 10 P2, 11 invalid
// ----------------------------------------------------------------------------
module baw_card_eval
    import baw_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NCARDS-1:0] p1_card,
    input  logic [NCARDS-1:0] p2_card,
    input  logic [NCARDS-1:0] p1_sel,
    input  logic [NCARDS-1:0] p2_sel,
    input  logic              eval_en,
    output logic [3:0]        p1_black,
    output logic [3:0]        p1_white,
    output logic [3:0]        p2_black,
    output logic [3:0]        p2_white,
    output logic [3:0]        p1_hand,
    output logic [3:0]        p2_hand,
    output logic              p1_hand_black,
    output logic              p2_hand_black,
    output logic              hand_valid,
    output logic [1:0]        match_result
);

    logic [3:0] w_p1_val;
    logic [3:0] w_p2_val;
    logic       w_p1_oh;
    logic       w_p2_oh;
    logic [1:0] w_result;

    logic [3:0] r_p1_black;
    logic [3:0] r_p1_white;
    logic [3:0] r_p2_black;
    logic [3:0] r_p2_white;
    logic [3:0] r_p1_hand;
    logic [3:0] r_p2_hand;
    logic       r_hand_valid;
    logic [1:0] r_match;

    baw_onehot_enc u_p1_enc (
        .i_sel    (p1_sel),
        .o_value  (w_p1_val),
        .o_onehot (w_p1_oh)
    );

    baw_onehot_enc u_p2_enc (
        .i_sel    (p2_sel),
        .o_value  (w_p2_val),
        .o_onehot (w_p2_oh)
    );

    always_comb begin
        w_result = MATCH_DRAW;
        if (!(w_p1_oh && w_p2_oh)) begin
            w_result = MATCH_INV;
        end
`ifdef BAW_ZERO_BEATS_EIGHT_EN
        else if (w_p1_val == 4'd0 && w_p2_val == 4'd8) begin
            w_result = MATCH_P1;
        end
        else if (w_p1_val == 4'd8 && w_p2_val == 4'd0) begin
            w_result = MATCH_P2;
        end
`endif
        else if (w_p1_val > w_p2_val) begin
            w_result = MATCH_P1;
        end
        else if (w_p2_val > w_p1_val) begin
            w_result = MATCH_P2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1_black   <= '0;
            r_p1_white   <= '0;
            r_p2_black   <= '0;
            r_p2_white   <= '0;
            r_p1_hand    <= '0;
            r_p2_hand    <= '0;
            r_hand_valid <= 1'b0;
            r_match      <= MATCH_DRAW;
        end else begin
            r_p1_black <= popcount9(p1_card & BLACK_MASK);
            r_p1_white <= popcount9(p1_card & WHITE_MASK);
            r_p2_black <= popcount9(p2_card & BLACK_MASK);
            r_p2_white <= popcount9(p2_card & WHITE_MASK);
            if (eval_en) begin
                r_p1_hand    <= w_p1_val;
                r_p2_hand    <= w_p2_val;
                r_hand_valid <= w_p1_oh & w_p2_oh;
                r_match      <= w_result;
            end
        end
    end

    assign p1_black      = r_p1_black;
    assign p1_white      = r_p1_white;
    assign p2_black      = r_p2_black;
    assign p2_white      = r_p2_white;
    assign p1_hand       = r_p1_hand;
    assign p2_hand       = r_p2_hand;
    assign p1_hand_black = r_p1_hand[0];
    assign p2_hand_black = r_p2_hand[0];
    assign hand_valid    = r_hand_valid;
    assign match_result  = r_match;

endmodule : baw_card_eval

// File: tb/tb_baw_card_eval.sv
// ----------------------------------------------------------------------------
// tb_baw_card_eval
//   Directed bench for baw_card_eval. Inputs change 1 time unit after the
//   rising edge and outputs are sampled at that same point, clear of the edge.
//   Honours BAW_ZERO_BEATS_EIGHT_EN for the 0-vs-8 expectations.
// ----------------------------------------------------------------------------
module tb_baw_card_eval;

    logic       clk;
    logic       reset;
    logic [8:0] p1_card;
    logic [8:0] p2_card;
    logic [8:0] p1_sel;
    logic [8:0] p2_sel;
    logic       eval_en;
    logic [3:0] p1_black;
    logic [3:0] p1_white;
    logic [3:0] p2_black;
    logic [3:0] p2_white;
    logic [3:0] p1_hand;
    logic [3:0] p2_hand;
    logic       p1_hand_black;
    logic       p2_hand_black;
    logic       hand_valid;
    logic [1:0] match_result;

    int checks = 0;
    int errors = 0;

    baw_card_eval dut (
        .clk           (clk),
        .reset         (reset),
        .p1_card       (p1_card),
        .p2_card       (p2_card),
        .p1_sel        (p1_sel),
        .p2_sel        (p2_sel),
        .eval_en       (eval_en),
        .p1_black      (p1_black),
        .p1_white      (p1_white),
        .p2_black      (p2_black),
        .p2_white      (p2_white),
        .p1_hand       (p1_hand),
        .p2_hand       (p2_hand),
        .p1_hand_black (p1_hand_black),
        .p2_hand_black (p2_hand_black),
        .hand_valid    (hand_valid),
        .match_result  (match_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] observed, input logic [8:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hand(input string tag, input logic [3:0] e1, input logic [3:0] e2,
                              input logic ev, input logic [1:0] em);
        check({tag, "_p1_hand"},  {5'd0, p1_hand}, {5'd0, e1});
        check({tag, "_p2_hand"},  {5'd0, p2_hand}, {5'd0, e2});
        check({tag, "_p1_hblk"},  {8'd0, p1_hand_black}, {8'd0, e1[0]});
        check({tag, "_p2_hblk"},  {8'd0, p2_hand_black}, {8'd0, e2[0]});
        check({tag, "_valid"},    {8'd0, hand_valid}, {8'd0, ev});
        check({tag, "_match"},    {7'd0, match_result}, {7'd0, em});
    endtask

    task automatic check_counts(input string tag, input logic [3:0] b1, input logic [3:0] w1,
                                input logic [3:0] b2, input logic [3:0] w2);
        check({tag, "_p1_black"}, {5'd0, p1_black}, {5'd0, b1});
        check({tag, "_p1_white"}, {5'd0, p1_white}, {5'd0, w1});
        check({tag, "_p2_black"}, {5'd0, p2_black}, {5'd0, b2});
        check({tag, "_p2_white"}, {5'd0, p2_white}, {5'd0, w2});
    endtask

    task automatic eval(input logic [8:0] s1, input logic [8:0] s2);
        p1_sel  = s1;
        p2_sel  = s2;
        eval_en = 1'b1;
        tick();
        eval_en = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        p1_card = '0;
        p2_card = '0;
        p1_sel  = '0;
        p2_sel  = '0;
        eval_en = 1'b0;
        tick();
        check_counts("rst", 4'd0, 4'd0, 4'd0, 4'd0);
        check_hand("rst", 4'd0, 4'd0, 1'b0, 2'b00);
        reset = 1'b0;

        // Counts, one-cycle latency
        p1_card = 9'h1FF;
        p2_card = 9'h000;
        tick();
        check_counts("cnt_full", 4'd4, 4'd5, 4'd0, 4'd0);
        p1_card = 9'h00F;
        p2_card = 9'h155;
        tick();
        check_counts("cnt_mix", 4'd2, 4'd2, 4'd0, 4'd5);
        p1_card = 9'h0AA;
        p2_card = 9'h1FF;
        tick();
        check_counts("cnt_blk", 4'd4, 4'd0, 4'd4, 4'd5);

        // 7 vs 2, then hold with eval_en low while selections change
        eval(9'h080, 9'h004);
        check_hand("p1win", 4'd7, 4'd2, 1'b1, 2'b01);
        p1_sel = 9'h001;
        p2_sel = 9'h002;
        tick();
        tick();
        check_hand("hold", 4'd7, 4'd2, 1'b1, 2'b01);

        eval(9'h010, 9'h010);
        check_hand("draw", 4'd4, 4'd4, 1'b1, 2'b00);
        eval(9'h001, 9'h002);
        check_hand("p2win", 4'd0, 4'd1, 1'b1, 2'b10);
        eval(9'h100, 9'h020);
        check_hand("p1win8", 4'd8, 4'd5, 1'b1, 2'b01);

        // Invalid selections
        eval(9'h003, 9'h004);
        check_hand("inv_multi", 4'd1, 4'd2, 1'b0, 2'b11);
        eval(9'h000, 9'h004);
        check_hand("inv_zero", 4'd0, 4'd2, 1'b0, 2'b11);
        eval(9'h040, 9'h180);
        check_hand("inv_p2", 4'd6, 4'd8, 1'b0, 2'b11);

        // 0 vs 8 in both seatings
`ifdef BAW_ZERO_BEATS_EIGHT_EN
        eval(9'h001, 9'h100);
        check_hand("zero_p1", 4'd0, 4'd8, 1'b1, 2'b01);
        eval(9'h100, 9'h001);
        check_hand("zero_p2", 4'd8, 4'd0, 1'b1, 2'b10);
`else
        eval(9'h001, 9'h100);
        check_hand("zero_p1", 4'd0, 4'd8, 1'b1, 2'b10);
        eval(9'h100, 9'h001);
        check_hand("zero_p2", 4'd8, 4'd0, 1'b1, 2'b01);
`endif
        // 0 vs 8 that is invalid stays invalid
        eval(9'h001, 9'h101);
        check_hand("zero_inv", 4'd0, 4'd8, 1'b0, 2'b11);

        // Mid-cycle asynchronous reset with eval_en high
        eval(9'h080, 9'h004);
        check_hand("pre_rst", 4'd7, 4'd2, 1'b1, 2'b01);
        p1_sel  = 9'h020;
        p2_sel  = 9'h001;
        eval_en = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        check_counts("arst", 4'd0, 4'd0, 4'd0, 4'd0);
        check_hand("arst", 4'd0, 4'd0, 1'b0, 2'b00);
        tick();
        check_counts("arst_hold", 4'd0, 4'd0, 4'd0, 4'd0);
        check_hand("arst_hold", 4'd0, 4'd0, 1'b0, 2'b00);
        eval_en = 1'b0;
        reset   = 1'b0;
        tick();
        check_hand("post_rst", 4'd0, 4'd0, 1'b0, 2'b00);
        check_counts("post_rst", 4'd4, 4'd0, 4'd4, 4'd5);
        eval(9'h020, 9'h001);
        check_hand("post_eval", 4'd5, 4'd0, 1'b1, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_baw_card_eval
